// File: rtl/div_controller.sv
// Sequencing controller for the iterative 32-bit RISC-V divider in EXE.
// Stalls the front of the pipeline while dividing and holds a registered result until EXE advances.
module div_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             exe_div,
    input  logic [1:0]       exe_op,
    input  logic [WIDTH-1:0] exe_a,
    input  logic [WIDTH-1:0] exe_b,
    input  logic             exe_adv,
    input  logic             flush,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_REM = 2'b10;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;

    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             overflow;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_sel;
    logic [WIDTH-1:0] r_sel;

    always_comb begin
        is_signed = !exe_op[0];
        a_abs     = (is_signed && exe_a[WIDTH-1]) ? -exe_a : exe_a;
        b_abs     = (is_signed && exe_b[WIDTH-1]) ? -exe_b : exe_b;
        b_zero    = (exe_b == '0);
        overflow  = is_signed && (exe_a == {1'b1, {(WIDTH-1){1'b0}}}) && (exe_b == '1);
        // Partial remainder stays below 2*divisor, so 33 bits cannot overflow
        partial   = {rem, quo[WIDTH-1]};
        diff      = partial - {1'b0, divisor};
        q_sel     = (op == OP_DIV && q_neg) ? -quo : quo;
        r_sel     = (op == OP_REM && r_neg) ? -rem : rem;
    end

    always_comb begin
        div_stall = !flush && (((state == IDLE) && exe_div) || (state == CALC) || (state == SIGN));
        div_done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            quo        <= '0;
            rem        <= '0;
            divisor    <= '0;
            div_result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (exe_div) begin
                        op    <= exe_op;
                        q_neg <= is_signed && (exe_a[WIDTH-1] ^ exe_b[WIDTH-1]);
                        r_neg <= is_signed && exe_a[WIDTH-1];
                        if (b_zero) begin
                            div_result <= exe_op[1] ? exe_a : '1;
                            state      <= DONE;
                        end else if (overflow) begin
                            div_result <= exe_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                            state      <= DONE;
                        end else begin
                            quo     <= a_abs;
                            rem     <= '0;
                            divisor <= b_abs;
                            cnt     <= CNT_W'(WIDTH - 1);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
                    if (cnt == '0) begin
                        state <= SIGN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SIGN: begin
                    div_result <= op[1] ? r_sel : q_sel;
                    state      <= DONE;
                end
                default: begin
                    if (exe_adv) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: directed corner cases plus random
// operations compared against an arithmetic reference of RISC-V divide semantics.
module tb_div_controller;

    logic        clk;
    logic        nrst;
    logic        exe_div;
    logic [1:0]  exe_op;
    logic [31:0] exe_a;
    logic [31:0] exe_b;
    logic        exe_adv;
    logic        flush;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;

    int          checks;
    int          errors;
    logic [31:0] last_res;

    div_controller #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .exe_div    (exe_div),
        .exe_op     (exe_op),
        .exe_a      (exe_a),
        .exe_b      (exe_b),
        .exe_adv    (exe_adv),
        .flush      (flush),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension results from plain arithmetic; SV signed / and % truncate toward zero
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one divide starting just after a rising edge; hold>1 keeps exe_adv low for hold DONE cycles
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        int          exp_stall;
        int          stalls;
        bit          seen;
        exp_res   = ref_result(op, a, b);
        exp_stall = ref_special(op, a, b) ? 1 : 34;
        exe_op    = op;
        exe_a     = a;
        exe_b     = b;
        exe_div   = 1'b1;
        exe_adv   = (hold <= 1);
        stalls    = 0;
        seen      = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (div_done) begin
                seen = 1'b1;
            end else begin
                if (div_stall) stalls++;
                @(posedge clk);
                #1;
            end
        end
        check_output("done_seen", 32'(seen), 32'd1);
        check_output("stall_cycles", 32'(stalls), 32'(exp_stall));
        check_output("stall_in_done", 32'(div_stall), 32'd0);
        check_output("result", div_result, exp_res);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("hold_done", 32'(div_done), 32'd1);
            check_output("hold_stall", 32'(div_stall), 32'd0);
            check_output("hold_result", div_result, exp_res);
        end
        exe_adv = 1'b1;
        @(posedge clk);
        #1;
        exe_div = 1'b0;
        @(negedge clk);
        check_output("idle_done", 32'(div_done), 32'd0);
        check_output("idle_stall", 32'(div_stall), 32'd0);
        last_res = exp_res;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        errors   = 0;
        last_res = 32'd0;
        nrst     = 1'b0;
        exe_div  = 1'b0;
        exe_op   = 2'b00;
        exe_a    = 32'd0;
        exe_b    = 32'd0;
        exe_adv  = 1'b1;
        flush    = 1'b0;

        #2;
        check_output("reset_stall", 32'(div_stall), 32'd0);
        check_output("reset_done", 32'(div_done), 32'd0);
        check_output("reset_result", div_result, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        @(negedge clk);
        check_output("nodiv_stall", 32'(div_stall), 32'd0);
        check_output("nodiv_done", 32'(div_done), 32'd0);
        @(posedge clk);
        #1;

        apply_stimulus(2'b01, 32'd100, 32'd7, 0);
        apply_stimulus(2'b11, 32'd100, 32'd7, 0);
        apply_stimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        apply_stimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 0);
        apply_stimulus(2'b00, 32'd5, 32'd0, 0);
        apply_stimulus(2'b11, 32'd5, 32'd0, 0);
        apply_stimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        apply_stimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush on the 10th CALC cycle must discard the operation
        exe_op  = 2'b01;
        exe_a   = 32'd1000;
        exe_b   = 32'd3;
        exe_div = 1'b1;
        exe_adv = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_output("calc_stall", 32'(div_stall), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_stall", 32'(div_stall), 32'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        exe_div = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_output("post_flush_done", 32'(div_done), 32'd0);
            check_output("post_flush_stall", 32'(div_stall), 32'd0);
            check_output("post_flush_result", div_result, last_res);
            @(posedge clk);
            #1;
        end
        apply_stimulus(2'b01, 32'd9, 32'd3, 0);

        exe_op  = 2'b01;
        exe_a   = 32'd50;
        exe_b   = 32'd5;
        exe_div = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        check_output("flush_issue_stall", 32'(div_stall), 32'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        exe_div = 1'b0;
        @(negedge clk);
        check_output("flush_issue_done", 32'(div_done), 32'd0);
        check_output("flush_issue_stall2", 32'(div_stall), 32'd0);
        @(posedge clk);
        #1;

        apply_stimulus(2'b01, 32'd12345, 32'd17, 5);

        // Asynchronous reset in the middle of CALC
        exe_op  = 2'b01;
        exe_a   = 32'd1234567;
        exe_b   = 32'd89;
        exe_div = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        nrst    = 1'b0;
        exe_div = 1'b0;
        #1;
        check_output("async_rst_stall", 32'(div_stall), 32'd0);
        check_output("async_rst_done", 32'(div_done), 32'd0);
        check_output("async_rst_result", div_result, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("after_rst_done", 32'(div_done), 32'd0);
        check_output("after_rst_stall", 32'(div_stall), 32'd0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2, 3:    rb = 32'($urandom_range(1, 20));
                4, 5:    rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            apply_stimulus(rop, ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_controller.md
Name: div_controller

Overview:
- Sequences the iterative M-extension divider for DIV/DIVU/REM/REMU in the EXE stage.
- Holds the IF/ID/EXE stages through a stall output while the divide runs, and presents a registered result when done.
- Short-cuts the RISC-V special cases (divide-by-zero, signed overflow).
- Aborts cleanly on a branch flush.
- Its stall is ORed with the load-use stalls into the pipeline enables.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported).
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  pipeline clock
- nrst  in  1  asynchronous active-low reset
- exe_div  in  1  divide-class instruction present in EXE
- exe_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- exe_a  in  WIDTH  dividend (forwarded rs1)
- exe_b  in  WIDTH  divisor (forwarded rs2)
- exe_adv  in  1  EXE/MEM register will capture this cycle (pipeline not otherwise stalled)
- flush  in  1  branch flush of the EXE instruction
- div_stall  out  1  hold IF, ID and EXE; bubble into MEM
- div_done  out  1  div_result valid for the EXE instruction
- div_result  out  WIDTH  quotient or remainder

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low (nrst low forces the reset state immediately, independent of clk).
- Reset state: IDLE, counter 0, div_result 0, div_done 0, internal operand/remainder registers 0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - If exe_div && !flush, latch op and operands.
  - Signed ops (DIV/REM) take absolute values of both operands. Record quotient sign (a[31]^b[31]) and remainder sign (a[31]).
  - If b==0: result = 0xFFFFFFFF (DIV/DIVU) or a (REM/REMU); go to DONE.
  - Else if signed && a==0x80000000 && b==0xFFFFFFFF: result = 0x80000000 (DIV) or 0 (REM); go to DONE.
  - Else go to CALC with counter = 31.
- CALC: one restoring-division step per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial subtract with a 33-bit difference. If non-negative, keep the difference and set the quotient LSB to 1.
  - At counter==0 go to SIGN; otherwise decrement the counter. Exactly 32 CALC cycles.
- SIGN:
  - Negate the quotient if the quotient sign is set (DIV only).
  - Negate the remainder if the remainder sign is set (REM only).
  - Register the selected value into div_result; go to DONE.
- DONE:
  - div_done=1 and div_stall=0.
  - Stay in DONE while !exe_adv; div_result is stable throughout.
  - Go to IDLE on the cycle exe_adv=1. A new exe_div is never accepted from DONE, so there is no re-issue of the same instruction.
- div_stall (combinational) = (IDLE && exe_div && !flush) || CALC || SIGN, all gated by !flush.
- Latency:
  - Normal op: div_stall high for 34 cycles (accept, 32 CALC, SIGN); div_done in cycle 35.
  - Special case: 1 stall cycle; div_done in the next cycle.
- Flush: in any state, flush forces IDLE next cycle; div_stall=0 in the flush cycle and div_done=0 next cycle. Any partial result is discarded and div_result keeps its last value.
- Simultaneous flush and exe_div in IDLE: flush wins and nothing is accepted.
- Non-divide cycles: exe_div=0 in IDLE keeps the block in IDLE with div_stall=0 and div_done=0.
- Reset mid-operation: returns to IDLE asynchronously with all outputs in their reset values.
- Arithmetic: all operations are modulo 2^32. Negation is two's complement. The absolute value of 0x80000000 is treated as unsigned 0x80000000.

Test Plan:
- DIVU a=100, b=7, exe_adv=1 -> div_stall high for exactly 34 cycles, then div_done=1 with div_result=14; REMU with the same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIV a=7, b=-2 -> 0xFFFFFFFD.
- DIV a=5, b=0 -> 1 stall cycle, div_result=0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after a 1-cycle stall; REM with the same operands -> 0.
- DIVU a=0xFFFFFFFF, b=1 -> 0xFFFFFFFF (full 32 iterations, no overflow of the 33-bit difference).
- Start DIVU, assert flush on the 10th CALC cycle -> div_stall=0 in that cycle, IDLE next cycle, div_done never asserted. A following DIVU 9/3 -> 3 with full latency.
- Hold exe_adv=0 for 5 cycles in DONE -> div_done=1 and div_result constant for all 5 cycles, div_stall=0. exe_adv=1 -> IDLE next cycle. nrst pulsed low mid-CALC -> all outputs 0 immediately.
